nanorv32_trace_ctrl: RTL



---
 rtl/nanorv32_trace_ctrl_pkg.sv | 36 +++
 rtl/nanorv32_ascii.sv | 96 +++++++++
 rtl/nanorv32_trace_fifo.sv | 58 +++++
 rtl/nanorv32_trace_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/nanorv32_trace_ctrl_pkg.sv
// Shared constants, types and text helpers for the retired-instruction trace controller.
// Pure definitions: no state, no latency, no flow control.
package nanorv32_trace_ctrl_pkg;

    localparam int         TRACE_LINE_LEN = 33;
    localparam logic [5:0] LAST_IDX       = 6'(TRACE_LINE_LEN - 1);

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_LF    = 8'h0A;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } rec_t;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // Byte 7 of the result holds the most significant nibble, so it prints first.
    function automatic logic [63:0] pc_hex(input logic [31:0] pc);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s[8*i +: 8] = hex_char(pc[4*i +: 4]);
        end
        return s;
    endfunction

endpackage

// File: rtl/nanorv32_ascii.sv
// Combinational RV32I disassembly text: 8-char mnemonic and 4-char ABI register names.
// Zero latency, no flow control.
module nanorv32_ascii (
    input  logic [31:0] i_instr,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rd2,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    output logic [63:0] o_mnem,
    output logic [31:0] o_rd_txt,
    output logic [31:0] o_rs1_txt,
    output logic [31:0] o_rs2_txt
);

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [4:0] w_dst;

    function automatic logic [31:0] reg_name(input logic [4:0] r);
        case (r)
            5'd0:  return "zero"; 5'd1:  return "ra  "; 5'd2:  return "sp  "; 5'd3:  return "gp  ";
            5'd4:  return "tp  "; 5'd5:  return "t0  "; 5'd6:  return "t1  "; 5'd7:  return "t2  ";
            5'd8:  return "s0  "; 5'd9:  return "s1  "; 5'd10: return "a0  "; 5'd11: return "a1  ";
            5'd12: return "a2  "; 5'd13: return "a3  "; 5'd14: return "a4  "; 5'd15: return "a5  ";
            5'd16: return "a6  "; 5'd17: return "a7  "; 5'd18: return "s2  "; 5'd19: return "s3  ";
            5'd20: return "s4  "; 5'd21: return "s5  "; 5'd22: return "s6  "; 5'd23: return "s7  ";
            5'd24: return "s8  "; 5'd25: return "s9  "; 5'd26: return "s10 "; 5'd27: return "s11 ";
            5'd28: return "t3  "; 5'd29: return "t4  "; 5'd30: return "t5  "; default: return "t6  ";
        endcase
    endfunction

    assign w_op = i_instr[6:0];
    assign w_f3 = i_instr[14:12];
    assign w_f7 = i_instr[31:25];

    // rd2 names the destination only when rd is x0; with rd2 tied to rd this prints rd raw.
    assign w_dst     = (i_rd != 5'd0) ? i_rd : i_rd2;
    assign o_rd_txt  = reg_name(w_dst);
    assign o_rs1_txt = reg_name(i_rs1);
    assign o_rs2_txt = reg_name(i_rs2);

    always_comb begin
        o_mnem = "UNDEF   ";
        case (w_op)
            7'h37: o_mnem = "lui     ";
            7'h17: o_mnem = "auipc   ";
            7'h6F: o_mnem = "jal     ";
            7'h67: if (w_f3 == 3'd0) o_mnem = "jalr    ";
            7'h63: case (w_f3)
                3'd0: o_mnem = "beq     "; 3'd1: o_mnem = "bne     ";
                3'd4: o_mnem = "blt     "; 3'd5: o_mnem = "bge     ";
                3'd6: o_mnem = "bltu    "; 3'd7: o_mnem = "bgeu    ";
                default: ;
            endcase
            7'h03: case (w_f3)
                3'd0: o_mnem = "lb      "; 3'd1: o_mnem = "lh      "; 3'd2: o_mnem = "lw      ";
                3'd4: o_mnem = "lbu     "; 3'd5: o_mnem = "lhu     ";
                default: ;
            endcase
            7'h23: case (w_f3)
                3'd0: o_mnem = "sb      "; 3'd1: o_mnem = "sh      "; 3'd2: o_mnem = "sw      ";
                default: ;
            endcase
            7'h13: case (w_f3)
                3'd0: o_mnem = "addi    "; 3'd2: o_mnem = "slti    "; 3'd3: o_mnem = "sltiu   ";
                3'd4: o_mnem = "xori    "; 3'd6: o_mnem = "ori     "; 3'd7: o_mnem = "andi    ";
                3'd1: if (w_f7 == 7'h00) o_mnem = "slli    ";
                default: begin
                    if (w_f7 == 7'h00)      o_mnem = "srli    ";
                    else if (w_f7 == 7'h20) o_mnem = "srai    ";
                end
            endcase
            7'h33: begin
                if (w_f7 == 7'h00) begin
                    case (w_f3)
                        3'd0: o_mnem = "add     "; 3'd1: o_mnem = "sll     ";
                        3'd2: o_mnem = "slt     "; 3'd3: o_mnem = "sltu    ";
                        3'd4: o_mnem = "xor     "; 3'd5: o_mnem = "srl     ";
                        3'd6: o_mnem = "or      "; default: o_mnem = "and     ";
                    endcase
                end else if (w_f7 == 7'h20) begin
                    if (w_f3 == 3'd0)      o_mnem = "sub     ";
                    else if (w_f3 == 3'd5) o_mnem = "sra     ";
                end
            end
            7'h0F: o_mnem = "fence   ";
            7'h73: begin
                if (i_instr == 32'h0000_0073)      o_mnem = "ecall   ";
                else if (i_instr == 32'h0010_0073) o_mnem = "ebreak  ";
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/nanorv32_trace_fifo.sv
// Synchronous record FIFO: a push is visible one cycle later, a push at full is accepted only with a pop.
// Backpressure is the caller's job: o_full/o_empty are flags, over-pushes are silently refused.
module nanorv32_trace_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_dout  = r_mem[r_rptr];

    assign w_rd = i_pop & ~o_empty;
    assign w_wr = i_push & (~o_full | w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level <= r_level + LW'(w_wr) - LW'(w_rd);
        end
    end

endmodule

// File: rtl/nanorv32_trace_ctrl.sv
// Captures retired (pc, instr) records into a FIFO and streams each as a 33-byte ASCII line;
// first byte two cycles after the push, one byte per handshake, tx_data held while tx_ready is low.
module nanorv32_trace_ctrl
    import nanorv32_trace_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          retire_valid,
    input  logic [31:0]                   retire_pc,
    input  logic [31:0]                   retire_instr,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [7:0]                    tx_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_W-1:0]             drop_cnt,
    output logic                          busy
);

    state_t              r_state;
    logic [5:0]          r_idx;
    rec_t                r_line;
    logic [DROP_W-1:0]   r_drop;

    logic                w_push_req;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_drop;
    logic [63:0]         w_dout;
    logic [63:0]         w_mnem;
    logic [31:0]         w_rd_txt;
    logic [31:0]         w_rs1_txt;
    logic [31:0]         w_rs2_txt;
    logic [263:0]        w_line;
    logic [263:0]        w_line_sh;

    assign w_push_req = retire_valid & enable;
    assign w_pop      = ~w_empty & ((r_state == ST_IDLE) |
                        ((r_state == ST_SEND) & tx_ready & (r_idx == LAST_IDX)));
    assign w_drop     = w_push_req & w_full & ~w_pop;

    nanorv32_trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (64)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_req),
        .i_din   ({retire_pc, retire_instr}),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    nanorv32_ascii u_ascii (
        .i_instr   (r_line.instr),
        .i_rd      (r_line.instr[11:7]),
        .i_rd2     (r_line.instr[11:7]),
        .i_rs1     (r_line.instr[19:15]),
        .i_rs2     (r_line.instr[24:20]),
        .o_mnem    (w_mnem),
        .o_rd_txt  (w_rd_txt),
        .o_rs1_txt (w_rs1_txt),
        .o_rs2_txt (w_rs2_txt)
    );

    // Whole line laid out byte 0 at the top; the current byte is shifted up to [263:256].
    assign w_line    = {pc_hex(r_line.pc), CH_SPACE, w_mnem, CH_SPACE, w_rd_txt, CH_COMMA,
                        w_rs1_txt, CH_COMMA, w_rs2_txt, CH_LF};
    assign w_line_sh = w_line << {r_idx, 3'b000};

    assign tx_valid = (r_state == ST_SEND);
    assign tx_data  = tx_valid ? w_line_sh[263:256] : 8'h00;
    assign busy     = tx_valid | ~w_empty;
    assign drop_cnt = r_drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_line  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_line  <= w_dout;
                        r_idx   <= '0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        if (r_idx != LAST_IDX) begin
                            r_idx <= r_idx + 6'd1;
                        end else begin
                            r_idx <= '0;
                            if (!w_empty) r_line  <= w_dout;
                            else          r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != '1)) begin
            r_drop <= r_drop + DROP_W'(1);
        end
    end

endmodule
